// File: rtl/cfir_tap_loader.sv
// cfir_tap_loader: 4-tap complex delay line + phase accumulator feeding CFIR multiplier operands; `define CFIR_UNDERRUN_CNT_EN adds underrun_cnt
module cfir_tap_loader #(
  parameter int PHASE_BITS = 3,
  parameter int ACC_W      = 16
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           in_real,
  input  logic [15:0]           in_imag,
  input  logic [ACC_W-1:0]      step,
  input  logic                  coef_we,
  input  logic [PHASE_BITS+1:0] coef_addr,
  input  logic [19:0]           coef_wdata,
  output logic                  out_valid,
  output logic [15:0]           multi1_a,
  output logic [15:0]           multi2_a,
  output logic [15:0]           multi3_a,
  output logic [15:0]           multi4_a,
  output logic [15:0]           multi5_a,
  output logic [15:0]           multi6_a,
  output logic [15:0]           multi7_a,
  output logic [15:0]           multi8_a,
  output logic [9:0]            multi1_b,
  output logic [9:0]            multi2_b,
  output logic [9:0]            multi3_b,
  output logic [9:0]            multi4_b,
  output logic [9:0]            multi5_b,
  output logic [9:0]            multi6_b,
  output logic [9:0]            multi7_b,
  output logic [9:0]            multi8_b
`ifdef CFIR_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_cnt
`endif
);
  localparam int NENT = 4 << PHASE_BITS;
  typedef enum logic [1:0] {FILL, EMIT, NEED} state_t;
  state_t                  state_q, state_d;
  logic [1:0]              fill_q, fill_d;
  logic [ACC_W-1:0]        mu_q, mu_d;
  logic [ACC_W:0]          acc;
  logic [PHASE_BITS-1:0]   phase;
  logic                    accept;
  logic [15:0]             tre_q [4];
  logic [15:0]             tre_d [4];
  logic [15:0]             tim_q [4];
  logic [15:0]             tim_d [4];
  logic [15:0]             are_q [4];
  logic [15:0]             are_d [4];
  logic [15:0]             aim_q [4];
  logic [15:0]             aim_d [4];
  logic [9:0]              bre_q [4];
  logic [9:0]              bre_d [4];
  logic [9:0]              bim_q [4];
  logic [9:0]              bim_d [4];
  logic [19:0]             coef_q [NENT];
  logic [19:0]             coef_d [NENT];
  logic                    out_valid_q, out_valid_d;
  // Ready is a pure state decode, held low while reset is asserted.
  assign in_ready = ~rst & (state_q != EMIT);
  assign accept   = in_valid & in_ready;
  assign acc      = {1'b0, mu_q} + {1'b0, step};
  assign phase    = mu_q[ACC_W-1 -: PHASE_BITS];
  // Next-state, delay-line shift, phase accumulation and operand capture.
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    mu_d        = mu_q;
    tre_d       = tre_q;
    tim_d       = tim_q;
    are_d       = are_q;
    aim_d       = aim_q;
    bre_d       = bre_q;
    bim_d       = bim_q;
    out_valid_d = 1'b0;
    if (accept) begin
      tre_d[0] = in_real;
      tim_d[0] = in_imag;
      for (int i = 1; i < 4; i++) begin
        tre_d[i] = tre_q[i-1];
        tim_d[i] = tim_q[i-1];
      end
    end
    if (state_q == FILL && accept) begin
      fill_d  = fill_q + 2'd1;
      mu_d    = (fill_q == 2'd3) ? '0 : mu_q;
      state_d = (fill_q == 2'd3) ? EMIT : FILL;
    end
    if (state_q == NEED && accept)
      state_d = EMIT;
    if (state_q == EMIT) begin
      out_valid_d = 1'b1;
      for (int i = 0; i < 4; i++) begin
        are_d[i] = tre_q[i];
        aim_d[i] = tim_q[i];
        bre_d[i] = coef_q[{phase, 2'(i)}][19:10];
        bim_d[i] = coef_q[{phase, 2'(i)}][9:0];
      end
      mu_d    = acc[ACC_W-1:0];
      state_d = acc[ACC_W] ? NEED : EMIT;
    end
  end
  // Coefficient bank write port; reads in the same cycle see the old contents.
  always_comb begin
    coef_d = coef_q;
    if (coef_we)
      coef_d[coef_addr] = coef_wdata;
  end
  // State, taps, operands and coefficient bank registers.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q     <= FILL;
      fill_q      <= '0;
      mu_q        <= '0;
      tre_q       <= '{default: '0};
      tim_q       <= '{default: '0};
      are_q       <= '{default: '0};
      aim_q       <= '{default: '0};
      bre_q       <= '{default: '0};
      bim_q       <= '{default: '0};
      coef_q      <= '{default: '0};
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      mu_q        <= mu_d;
      tre_q       <= tre_d;
      tim_q       <= tim_d;
      are_q       <= are_d;
      aim_q       <= aim_d;
      bre_q       <= bre_d;
      bim_q       <= bim_d;
      coef_q      <= coef_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign out_valid = out_valid_q;
  assign multi1_a  = are_q[0];
  assign multi2_a  = are_q[1];
  assign multi3_a  = are_q[2];
  assign multi4_a  = are_q[3];
  assign multi5_a  = aim_q[0];
  assign multi6_a  = aim_q[1];
  assign multi7_a  = aim_q[2];
  assign multi8_a  = aim_q[3];
  assign multi1_b  = bre_q[0];
  assign multi2_b  = bre_q[1];
  assign multi3_b  = bre_q[2];
  assign multi4_b  = bre_q[3];
  assign multi5_b  = bim_q[0];
  assign multi6_b  = bim_q[1];
  assign multi7_b  = bim_q[2];
  assign multi8_b  = bim_q[3];
`ifdef CFIR_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;
  // Count starved cycles in NEED, saturating at all-ones.
  always_comb
    ucnt_d = (state_q == NEED && !in_valid && ucnt_q != 16'hFFFF) ? ucnt_q + 16'd1 : ucnt_q;
  // Underrun counter register, cleared only by reset.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst)
      ucnt_q <= '0;
    else
      ucnt_q <= ucnt_d;
  end
  assign underrun_cnt = ucnt_q;
`endif
endmodule

// File: tb/tb_cfir_tap_loader.sv
// tb_cfir_tap_loader: directed self-checking bench for cfir_tap_loader
module tb_cfir_tap_loader;
  logic        CLK = 1'b0, rst = 1'b1, in_valid = 1'b0, coef_we = 1'b0;
  logic [15:0] in_real = '0, in_imag = '0, step = '0;
  logic [4:0]  coef_addr = '0;
  logic [19:0] coef_wdata = '0;
  logic        in_ready, out_valid;
  logic [15:0] multi1_a, multi2_a, multi3_a, multi4_a, multi5_a, multi6_a, multi7_a, multi8_a;
  logic [9:0]  multi1_b, multi2_b, multi3_b, multi4_b, multi5_b, multi6_b, multi7_b, multi8_b;
`ifdef CFIR_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif
  int n_chk = 0, n_err = 0;
  cfir_tap_loader dut (
    .CLK(CLK), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .step(step),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(out_valid),
    .multi1_a(multi1_a), .multi2_a(multi2_a), .multi3_a(multi3_a), .multi4_a(multi4_a),
    .multi5_a(multi5_a), .multi6_a(multi6_a), .multi7_a(multi7_a), .multi8_a(multi8_a),
    .multi1_b(multi1_b), .multi2_b(multi2_b), .multi3_b(multi3_b), .multi4_b(multi4_b),
    .multi5_b(multi5_b), .multi6_b(multi6_b), .multi7_b(multi7_b), .multi8_b(multi8_b)
`ifdef CFIR_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );
  always #5 CLK = ~CLK;
  function automatic logic [9:0] cre(input int p, input int t);
    return 10'(p * 8 + t + 1);
  endfunction
  function automatic logic [9:0] cim(input int p, input int t);
    return 10'(-(p * 8 + t + 1));
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic feed(input logic [15:0] r, input logic [15:0] im);
    in_valid = 1'b1;
    in_real  = r;
    in_imag  = im;
    tick;
    in_valid = 1'b0;
  endtask
  logic ov_exp [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  int   ph_exp [9] = '{0, 0, 6, 0, 4, 0, 2, 0, 0};
  initial begin
    tick;
    tick;
    chk("rst_ov", out_valid, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_m1a", multi1_a, 0);
    chk("rst_m8a", multi8_a, 0);
    chk("rst_m4b", multi4_b, 0);
    chk("rst_m8b", multi8_b, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", in_ready, 1);
    for (int p = 0; p < 8; p++)
      for (int t = 0; t < 4; t++) begin
        coef_we    = 1'b1;
        coef_addr  = 5'(p * 4 + t);
        coef_wdata = {cre(p, t), cim(p, t)};
        tick;
      end
    coef_we = 1'b0;
    chk("fill_idle_ov", out_valid, 0);
    step = 16'h4000;
    for (int k = 1; k <= 4; k++)
      feed(16'(k), 16'(16'h0100 + k));
    chk("fill_emit_ov", out_valid, 0);
    chk("fill_emit_ready", in_ready, 0);
    for (int j = 0; j < 4; j++) begin
      tick;
      chk("s4_ov", out_valid, 1);
      chk("s4_m1b", multi1_b, cre(2 * j, 0));
      chk("s4_m4b", multi4_b, cre(2 * j, 3));
      chk("s4_m8b", multi8_b, cim(2 * j, 3));
      if (j == 0) begin
        chk("fill_m1a", multi1_a, 16'h0004);
        chk("fill_m2a", multi2_a, 16'h0003);
        chk("fill_m4a", multi4_a, 16'h0001);
        chk("fill_m5a", multi5_a, 16'h0104);
        chk("fill_m8a", multi8_a, 16'h0101);
      end
    end
    chk("s4_need_ready", in_ready, 1);
    step = 16'h2000;
    feed(16'h0005, 16'h0105);
    chk("sweep_lat_ov", out_valid, 0);
    for (int p = 0; p < 8; p++) begin
      tick;
      chk("sweep_ov", out_valid, 1);
      chk("sweep_m1b", multi1_b, cre(p, 0));
      chk("sweep_m8b", multi8_b, cim(p, 3));
      if (p == 0) begin
        chk("sweep_m1a", multi1_a, 16'h0005);
        chk("sweep_m4a", multi4_a, 16'h0002);
      end
    end
    chk("sweep_need_ready", in_ready, 1);
    step     = 16'hC000;
    in_valid = 1'b1;
    in_real  = 16'h0010;
    in_imag  = 16'h0110;
    for (int i = 0; i < 9; i++) begin
      tick;
      chk("big_ov", out_valid, ov_exp[i]);
      if (ov_exp[i])
        chk("big_phase", multi1_b, cre(ph_exp[i], 0));
    end
    in_valid = 1'b0;
    tick;
    chk("big_last_ov", out_valid, 1);
    chk("big_last_phase", multi1_b, cre(6, 0));
    chk("big_need_ready", in_ready, 1);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("starve_ov", out_valid, 0);
    end
    chk("starve_ready", in_ready, 1);
    chk("starve_hold", multi1_b, cre(6, 0));
`ifdef CFIR_UNDERRUN_CNT_EN
    chk("underrun_cnt", underrun_cnt, 10);
`endif
    feed(16'h000A, 16'h020A);
    chk("resume_lat_ov", out_valid, 0);
    tick;
    chk("resume_ov", out_valid, 1);
    chk("resume_phase", multi1_b, cre(4, 0));
    chk("resume_m1a", multi1_a, 16'h000A);
    feed(16'h000B, 16'h020B);
    chk("pre_col_lat_ov", out_valid, 0);
    tick;
    chk("pre_col_ov", out_valid, 1);
    chk("pre_col_phase", multi1_b, cre(2, 0));
    chk("pre_col_ready", in_ready, 1);
    step = 16'h0000;
    feed(16'h000C, 16'h020C);
    coef_we    = 1'b1;
    coef_addr  = 5'd0;
    coef_wdata = {10'h3FF, 10'h001};
    chk("col_emit_ov", out_valid, 0);
    tick;
    coef_we = 1'b0;
    chk("col_old_ov", out_valid, 1);
    chk("col_old_re", multi1_b, cre(0, 0));
    chk("col_old_im", multi5_b, cim(0, 0));
    tick;
    chk("col_new_ov", out_valid, 1);
    chk("col_new_re", multi1_b, 10'h3FF);
    chk("col_new_im", multi5_b, 10'h001);
    chk("col_tap1_re", multi2_b, cre(0, 1));
    chk("col_m1a", multi1_a, 16'h000C);
    chk("step0_ready", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_m1a", multi1_a, 0);
    chk("mid_rst_m1b", multi1_b, 0);
    chk("mid_rst_m5b", multi5_b, 0);
    tick;
    rst = 1'b0;
    #1;
    chk("mid_rel_ready", in_ready, 1);
    for (int k = 1; k <= 3; k++)
      feed(16'(16'h0030 + k), 16'(16'h0130 + k));
    tick;
    tick;
    chk("refill_ov", out_valid, 0);
    chk("refill_ready", in_ready, 1);
    feed(16'h0034, 16'h0134);
    chk("refill_emit_ov", out_valid, 0);
    tick;
    chk("refill_out_ov", out_valid, 1);
    chk("refill_m1a", multi1_a, 16'h0034);
    chk("refill_m4a", multi4_a, 16'h0031);
    chk("refill_m8a", multi8_a, 16'h0131);
    chk("refill_m1b", multi1_b, 0);
    chk("refill_m8b", multi8_b, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
